// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Data-hazard controller for an in-order pipeline. It tracks the instruction
//   in EX plus N_STG older writer stages (MA, WB, WB-hold, ...), chooses EX
//   operand bypass sources, and produces the IF/ID stall and the IF/ID and
//   ID/EX flushes. Control outputs are combinational from the scoreboard and
//   the current ID/EX inputs.
//
//   Parameters
//     N_STG    : tracked post-EX writer stages (2..6)
//     FWD_MODE : 1 = bypass from tracked stages, 0 = interlock only
//     SEL_W    : width of each forward select, 2**SEL_W > N_STG
//
//   Ports
//     clk, reset_n              : rising-edge clock, async active-low reset
//     id_valid                  : ID stage holds a real instruction
//     id_rs1/id_rs2/id_rd       : ID register addresses
//     id_use_rs1/id_use_rs2     : ID source-operand use flags
//     id_we/id_is_load          : ID register-write and load flags
//     br_taken_ex               : branch/jump resolved taken in EX
//     fwd_sel_a/fwd_sel_b       : EX operand source, 0 = regfile, k = stage k
//     stall_if_id               : hold PC and IF/ID
//     flush_if_id/flush_id_ex   : turn IF/ID and ID/EX contents into bubbles
//     stall_cnt/flush_cnt       : saturating performance counters
//
//   Build option
//     HAZ_PERF_CNT_EN : when defined, stall_cnt/flush_cnt count stall cycles
//                       and taken-branch cycles; otherwise both read as 0 and
//                       no counter flops exist.
module pipe_hazard_ctrl #(
  parameter int unsigned N_STG    = 3,
  parameter int unsigned FWD_MODE = 1,
  parameter int unsigned SEL_W    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             br_taken_ex,
  output logic [SEL_W-1:0] fwd_sel_a,
  output logic [SEL_W-1:0] fwd_sel_b,
  output logic             stall_if_id,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       is_load;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs1;
    logic       use_rs2;
  } entry_t;

  entry_t           ex_q;
  entry_t           ex_d;
  entry_t [N_STG:1] stg_q;   // stg_q[1] = MA, stg_q[N_STG] = oldest
  logic             hazard;
  logic             unused_stg_bits;

  // x0 is hard-wired zero: an rd=0 entry never produces a value.
  function automatic logic is_writer(input entry_t e);
    return e.valid && e.we && (e.rd != 5'd0);
  endfunction

  function automatic logic fwd_hit(input entry_t w, input logic [4:0] rs,
                                   input logic use_rs);
    return is_writer(w) && use_rs && (w.rd == rs);
  endfunction

  function automatic logic src_hit(input entry_t w,
                                   input logic [4:0] rs1, input logic use1,
                                   input logic [4:0] rs2, input logic use2);
    return fwd_hit(w, rs1, use1) || fwd_hit(w, rs2, use2);
  endfunction

  // Bypass select: scan from oldest to youngest so the youngest matching
  // writer (lowest stage number) is the last assignment and wins.
  always_comb begin
    fwd_sel_a = '0;
    fwd_sel_b = '0;
    if (FWD_MODE != 0 && ex_q.valid) begin
      for (int unsigned k = N_STG; k >= 1; k--) begin
        if (fwd_hit(stg_q[k], ex_q.rs1, ex_q.use_rs1)) fwd_sel_a = SEL_W'(k);
        if (fwd_hit(stg_q[k], ex_q.rs2, ex_q.use_rs2)) fwd_sel_b = SEL_W'(k);
      end
    end
  end

  // With bypass only a load still in EX cannot feed the next instruction.
  // Without bypass the consumer waits until the writer reaches the last
  // tracked stage, whose result is in the register file by the time it reads.
  always_comb begin
    hazard = 1'b0;
    if (id_valid) begin
      if (FWD_MODE != 0) begin
        hazard = ex_q.is_load &&
                 src_hit(ex_q, id_rs1, id_use_rs1, id_rs2, id_use_rs2);
      end else begin
        hazard = src_hit(ex_q, id_rs1, id_use_rs1, id_rs2, id_use_rs2);
        for (int unsigned k = 1; k < N_STG; k++) begin
          if (src_hit(stg_q[k], id_rs1, id_use_rs1, id_rs2, id_use_rs2))
            hazard = 1'b1;
        end
      end
    end
  end

  // A taken branch discards the dependent instruction, so flush beats stall.
  assign flush_if_id = reset_n & br_taken_ex;
  assign flush_id_ex = reset_n & br_taken_ex;
  assign stall_if_id = reset_n & hazard & ~br_taken_ex;

  always_comb begin
    ex_d = '0;
    if (id_valid && !stall_if_id && !flush_id_ex) begin
      ex_d.valid   = 1'b1;
      ex_d.rd      = id_rd;
      ex_d.we      = id_we;
      ex_d.is_load = id_is_load;
      ex_d.rs1     = id_rs1;
      ex_d.rs2     = id_rs2;
      ex_d.use_rs1 = id_use_rs1;
      ex_d.use_rs2 = id_use_rs2;
    end
  end

  // Older stages always advance; a flush only replaces what enters EX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q  <= '0;
      stg_q <= '0;
    end else begin
      ex_q  <= ex_d;
      stg_q <= {stg_q[N_STG-1:1], ex_q};
    end
  end

  // Source fields of the older stages are kept for visibility only.
  assign unused_stg_bits = ^stg_q;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;
  logic [31:0] flush_cnt_q;
  logic [31:0] flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_if_id && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
    if (br_taken_ex && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl. Three instances share one stimulus stream:
//   0: N_STG=3 FWD_MODE=1, 1: N_STG=2 FWD_MODE=1, 2: N_STG=3 FWD_MODE=0.
// Each scenario starts from reset and targets one instance; expected values
// are queued when inputs are driven and compared on the following negedge.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       we;
    logic       ld;
  } ins_t;

  typedef struct {
    int inst;
    int a;
    int b;
    int st;
    int fif;
    int fex;
    int sc;
    int fc;
  } exp_t;

`ifdef HAZ_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  ins_t id = '0;
  logic br = 1'b0;

  logic [2:0]  sa  [3];
  logic [2:0]  sb  [3];
  logic        st  [3];
  logic        fif [3];
  logic        fex [3];
  logic [31:0] sc  [3];
  logic [31:0] fc  [3];

  exp_t  exp_q[$];
  string tag_q[$];
  int    m_sc [3];
  int    m_fc [3];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.N_STG(3), .FWD_MODE(1), .SEL_W(3)) u_n3_fwd (
    .clk(clk), .reset_n(reset_n), .id_valid(id.v),
    .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd),
    .id_use_rs1(id.u1), .id_use_rs2(id.u2), .id_we(id.we), .id_is_load(id.ld),
    .br_taken_ex(br), .fwd_sel_a(sa[0]), .fwd_sel_b(sb[0]),
    .stall_if_id(st[0]), .flush_if_id(fif[0]), .flush_id_ex(fex[0]),
    .stall_cnt(sc[0]), .flush_cnt(fc[0]));

  pipe_hazard_ctrl #(.N_STG(2), .FWD_MODE(1), .SEL_W(3)) u_n2_fwd (
    .clk(clk), .reset_n(reset_n), .id_valid(id.v),
    .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd),
    .id_use_rs1(id.u1), .id_use_rs2(id.u2), .id_we(id.we), .id_is_load(id.ld),
    .br_taken_ex(br), .fwd_sel_a(sa[1]), .fwd_sel_b(sb[1]),
    .stall_if_id(st[1]), .flush_if_id(fif[1]), .flush_id_ex(fex[1]),
    .stall_cnt(sc[1]), .flush_cnt(fc[1]));

  pipe_hazard_ctrl #(.N_STG(3), .FWD_MODE(0), .SEL_W(3)) u_n3_ilk (
    .clk(clk), .reset_n(reset_n), .id_valid(id.v),
    .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd),
    .id_use_rs1(id.u1), .id_use_rs2(id.u2), .id_we(id.we), .id_is_load(id.ld),
    .br_taken_ex(br), .fwd_sel_a(sa[2]), .fwd_sel_b(sb[2]),
    .stall_if_id(st[2]), .flush_if_id(fif[2]), .flush_id_ex(fex[2]),
    .stall_cnt(sc[2]), .flush_cnt(fc[2]));

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Instruction builders.
  function automatic ins_t alu(input int rd, input int rs1);
    ins_t i;
    i = '0;
    i.v = 1'b1; i.rd = 5'(rd); i.rs1 = 5'(rs1); i.u1 = 1'b1; i.we = 1'b1;
    return i;
  endfunction

  function automatic ins_t add(input int rd, input int rs1, input int rs2);
    ins_t i;
    i = alu(rd, rs1);
    i.rs2 = 5'(rs2); i.u2 = 1'b1;
    return i;
  endfunction

  function automatic ins_t lw(input int rd, input int rs1);
    ins_t i;
    i = alu(rd, rs1);
    i.ld = 1'b1;
    return i;
  endfunction

  localparam ins_t NOP = '0;

  // One cycle of stimulus for instance 'inst' with its expected outputs.
  task automatic step(input int inst, input string tag, input ins_t ins,
                      input logic b, input int ea, input int eb, input int es);
    exp_t e;
    reset_n = 1'b1;
    id = ins;
    br = b;
    e.inst = inst; e.a = ea; e.b = eb; e.st = es;
    e.fif = int'(b); e.fex = int'(b);
    e.sc = CNT_EN ? m_sc[inst] : 0;
    e.fc = CNT_EN ? m_fc[inst] : 0;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    m_sc[inst] += es;
    m_fc[inst] += int'(b);
    @(posedge clk);
    #1;
  endtask

  // One cycle held in reset: every instance must show all-zero outputs.
  task automatic rst_step(input string tag, input ins_t ins, input logic b);
    exp_t e;
    reset_n = 1'b0;
    id = ins;
    br = b;
    for (int i = 0; i < 3; i++) begin
      e.inst = i; e.a = 0; e.b = 0; e.st = 0; e.fif = 0; e.fex = 0;
      e.sc = 0; e.fc = 0;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      m_sc[i] = 0;
      m_fc[i] = 0;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t  e;
    string t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_val({t, ".sel_a"},   32'(sa[e.inst]),  32'(e.a));
      check_val({t, ".sel_b"},   32'(sb[e.inst]),  32'(e.b));
      check_val({t, ".stall"},   32'(st[e.inst]),  32'(e.st));
      check_val({t, ".fl_ifid"}, 32'(fif[e.inst]), 32'(e.fif));
      check_val({t, ".fl_idex"}, 32'(fex[e.inst]), 32'(e.fex));
      check_val({t, ".scnt"},    sc[e.inst],       32'(e.sc));
      check_val({t, ".fcnt"},    fc[e.inst],       32'(e.fc));
    end
  end

  // Writer x9 three instructions ahead of its consumer.
  task automatic deep_seq(input int inst, input int exp_sel);
    rst_step("deep.rst", lw(7, 2), 1'b1);
    step(inst, "deep.w9",  alu(9, 1),     1'b0, 0, 0, 0);
    step(inst, "deep.f10", alu(10, 1),    1'b0, 0, 0, 0);
    step(inst, "deep.f11", alu(11, 1),    1'b0, 0, 0, 0);
    step(inst, "deep.use", add(12, 9, 0), 1'b0, 0, 0, 0);
    step(inst, "deep.ex",  NOP,           1'b0, exp_sel, 0, 0);
  endtask

  initial begin
    ins_t inv;
    @(posedge clk);
    #1;

    // Reset with a hazard and a taken branch at the inputs.
    rst_step("rst", add(8, 7, 0), 1'b1);

    // Back-to-back ALU forwarding.
    step(0, "alu.addi",  alu(5, 1),     1'b0, 0, 0, 0);
    step(0, "alu.add",   add(6, 5, 5),  1'b0, 0, 0, 0);
    step(0, "alu.ex",    NOP,           1'b0, 1, 1, 0);
    step(0, "alu.drain", NOP,           1'b0, 0, 0, 0);

    // Load-use: one bubble, then bypass from WB.
    rst_step("lu.rst", lw(7, 2), 1'b1);
    step(0, "lu.lw",    lw(7, 2),      1'b0, 0, 0, 0);
    step(0, "lu.stall", add(8, 7, 0),  1'b0, 0, 0, 1);
    step(0, "lu.hold",  add(8, 7, 0),  1'b0, 0, 0, 0);
    step(0, "lu.ex",    NOP,           1'b0, 2, 0, 0);

    // Deep forwarding with three and with two tracked stages.
    deep_seq(0, 3);
    deep_seq(1, 0);

    // x0 writer is never a source; youngest of two x4 writers wins.
    rst_step("x0.rst", lw(7, 2), 1'b1);
    step(0, "x0.w",       alu(0, 1),      1'b0, 0, 0, 0);
    step(0, "x0.use",     alu(13, 0),     1'b0, 0, 0, 0);
    step(0, "x0.ex",      alu(4, 1),      1'b0, 0, 0, 0);
    step(0, "multi.w2",   alu(4, 1),      1'b0, 0, 0, 0);
    step(0, "multi.use",  add(14, 4, 4),  1'b0, 0, 0, 0);
    step(0, "multi.ex",   NOP,            1'b0, 1, 1, 0);

    // Load-use coinciding with a taken branch; the load still drains.
    rst_step("br.rst", lw(7, 2), 1'b1);
    step(0, "br.lw",    lw(7, 2),      1'b0, 0, 0, 0);
    step(0, "br.lu",    add(8, 7, 0),  1'b1, 0, 0, 0);
    step(0, "br.after", add(8, 7, 0),  1'b0, 0, 0, 0);
    step(0, "br.drain", NOP,           1'b0, 2, 0, 0);

    // Interlock-only: writer blocks consumer for three cycles.
    rst_step("il.rst", lw(7, 2), 1'b1);
    step(2, "il.addi", alu(5, 1),     1'b0, 0, 0, 0);
    step(2, "il.s1",   add(6, 5, 0),  1'b0, 0, 0, 1);
    step(2, "il.s2",   add(6, 5, 0),  1'b0, 0, 0, 1);
    step(2, "il.s3",   add(6, 5, 0),  1'b0, 0, 0, 1);
    step(2, "il.go",   add(6, 5, 0),  1'b0, 0, 0, 0);
    step(2, "il.ex",   NOP,           1'b0, 0, 0, 0);

    // Interlock ignores x0 writers and invalid ID contents.
    rst_step("inv.rst", lw(7, 2), 1'b1);
    inv = add(6, 5, 5);
    inv.v = 1'b0;
    step(2, "x0il.w",   alu(0, 1),  1'b0, 0, 0, 0);
    step(2, "x0il.use", alu(6, 0),  1'b0, 0, 0, 0);
    step(2, "inv.w",    alu(5, 1),  1'b0, 0, 0, 0);
    step(2, "inv.use",  inv,        1'b0, 0, 0, 0);
    step(2, "inv.ex",   NOP,        1'b0, 0, 0, 0);

    // Reset during a stall clears the scoreboard at once; the first edge
    // after release loads the valid ID instruction into EX.
    rst_step("rs.rst", lw(7, 2), 1'b1);
    step(2, "rs.addi",  alu(5, 1),     1'b0, 0, 0, 0);
    step(2, "rs.stall", add(6, 5, 0),  1'b0, 0, 0, 1);
    rst_step("rs.mid", add(6, 5, 0), 1'b0);
    step(2, "rs.rel",   add(6, 5, 0),  1'b0, 0, 0, 0);
    step(2, "rs.load",  add(7, 6, 0),  1'b0, 0, 0, 1);
    step(2, "rs.end",   NOP,           1'b0, 0, 0, 0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL provide parameter N_STG, default 3, meaning the number of tracked post-EX writer stages (MA, WB, WB-hold); legal range 2..6.
REQ-002 SHALL provide parameter FWD_MODE, default 1: 1 = bypass from tracked stages, 0 = interlock only (stall until the writer leaves the last stage).
REQ-003 SHALL provide parameter SEL_W, default 3, meaning the width of each forward select; it must satisfy 2^SEL_W > N_STG.
REQ-004 SHALL have: clk  in  1  single clock, rising edge.
REQ-005 SHALL have: reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have: id_valid  in  1  the ID stage holds a real instruction.
REQ-007 SHALL have: id_rs1, id_rs2, id_rd  in  5 each  register addresses of the ID instruction.
REQ-008 SHALL have: id_use_rs1, id_use_rs2, id_we, id_is_load  in  1 each  ID operand-use, register-write and load flags.
REQ-009 SHALL have: br_taken_ex  in  1  branch or jump resolved taken in EX this cycle.
REQ-010 SHALL have: fwd_sel_a, fwd_sel_b  out  SEL_W  EX operand source: 0 = register file, k = tracked stage k (1 = MA).
REQ-011 SHALL have: stall_if_id  out  1  hold the PC and the IF/ID register.
REQ-012 SHALL have: flush_if_id, flush_id_ex  out  1  convert the IF/ID and ID/EX contents to bubbles.
REQ-013 SHALL have: stall_cnt, flush_cnt  out  32 each  performance counters (see Configuration).

Function
REQ-014 SHALL keep a scoreboard of one EX entry plus N_STG stage entries, each entry holding {valid, rd, we, is_load, rs1, rs2, use_rs1, use_rs2}.
REQ-015 SHALL advance every clock: EX entry -> stage 1, stage k -> stage k+1, stage N_STG discarded.
REQ-016 SHALL load the EX entry from the id_* inputs when there is no stall and no flush; it SHALL load an invalid bubble when stall_if_id or flush_id_ex is high.
REQ-017 SHALL treat an entry as a writer only when valid=1, we=1 and rd!=0; x0 is never forwarded and never causes a stall.
REQ-018 SHALL, with FWD_MODE=1, drive fwd_sel_a as the lowest-numbered stage k whose writer rd equals the EX rs1 with use_rs1=1, else 0; fwd_sel_b SHALL be derived the same way from rs2.
REQ-019 SHALL, with FWD_MODE=1, raise stall_if_id when the EX entry is a load writer whose rd matches a used ID source (load-use, exactly 1 bubble).
REQ-020 SHALL, with FWD_MODE=0, hold fwd_sel_a and fwd_sel_b at 0 and stall while any writer in the EX entry or stages 1..N_STG-1 matches a used ID source.
REQ-021 SHALL derive stall_if_id, flush_if_id, flush_id_ex and fwd_sel combinationally from the scoreboard and the current inputs, with 0-cycle latency.
REQ-022 SHALL, on br_taken_ex=1, assert flush_if_id=1 and flush_id_ex=1 in the same cycle and force stall_if_id=0; flush overrides stall.
REQ-023 SHALL ignore the id_* inputs and generate no stall when id_valid=0.
REQ-024 SHALL leave the contents of stages 1..N_STG unaffected by a flush; older instructions drain normally.

Reset
REQ-025 SHALL, while reset_n=0, clear all entry valid bits and force fwd_sel_a=0, fwd_sel_b=0, stall_if_id=0, flush_if_id=0, flush_id_ex=0, stall_cnt=0 and flush_cnt=0.
REQ-026 SHALL, on reset asserted mid-stall, drop the stall immediately; the first edge after release loads a bubble into EX unless id_valid=1.

Configuration
REQ-027 SHALL use macro HAZ_PERF_CNT_EN to include or exclude the performance counters.
REQ-028 SHALL, when HAZ_PERF_CNT_EN is defined, increment stall_cnt on each clock with stall_if_id=1 and flush_cnt on each clock with br_taken_ex=1, both saturating at 0xFFFFFFFF.
REQ-029 SHALL, when HAZ_PERF_CNT_EN is undefined, tie stall_cnt and flush_cnt to 0 and instantiate no counter flops.

Verification
REQ-030 SHALL cover back-to-back ALU forwarding: addi x5 then add x6,x5,x5 with FWD_MODE=1 -> fwd_sel_a=1 and fwd_sel_b=1 in the EX cycle of add, no stall.
REQ-031 SHALL cover load-use: lw x7 then add x8,x7,x0 -> stall_if_id=1 for exactly 1 cycle, next cycle fwd_sel_a=2, stall_cnt=1.
REQ-032 SHALL cover deep forwarding: writer x9 three instructions ahead with N_STG=3 -> fwd_sel=3; with N_STG=2 the same sequence -> fwd_sel=0.
REQ-033 SHALL cover x0 and multiple writers: rd=0 writer -> fwd_sel=0; x4 written in stages 1 and 2 -> fwd_sel=1 (youngest wins).
REQ-034 SHALL cover simultaneous load-use and br_taken_ex=1 -> flush_if_id=1, flush_id_ex=1, stall_if_id=0, flush_cnt increments and stall_cnt does not.
REQ-035 SHALL cover interlock: FWD_MODE=0 with addi x5 then add x6,x5,x0 and N_STG=3 -> stall_if_id=1 for 3 cycles, fwd_sel always 0.
